// File: rtl/car_move_scheduler_pkg.sv
// Shared definitions for the lane-traffic scheduler: grid geometry, direction
// encodings, scan FSM states and the level-scaled period helper.
package car_move_scheduler_pkg;

    localparam int POS_W  = 6;
    localparam int GRID_W = 40;
    localparam int GRID_H = 30;
    localparam int PER_W  = 4;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } scan_state_t;

    // Base period shortened by level; the 5-bit difference exposes underflow in its MSB.
    function automatic logic [PER_W-1:0] eff_period(input logic [PER_W-1:0] base,
                                                   input logic [2:0]       level);
        logic [PER_W:0] diff;
        diff = {1'b0, base} - {2'b00, level};
        if (diff[PER_W] || (diff == '0))
            return PER_W'(1);
        return diff[PER_W-1:0];
    endfunction

endpackage

// File: rtl/car_move_scheduler_step_unit.sv
// Shared X stepper: moves one position left or right with wrap at the grid edges.
// Purely combinational, zero latency, no flow control.
module car_step_unit
    import car_move_scheduler_pkg::*;
(
    input  logic [POS_W-1:0] x,
    input  logic             dir,
    input  logic [POS_W-1:0] max_x,
    output logic [POS_W-1:0] next_x
);

    always_comb begin
        next_x = x;
        if (dir == DIR_RIGHT)
            next_x = (x == max_x - POS_W'(1)) ? '0 : x + POS_W'(1);
        else
            next_x = (x == '0) ? max_x - POS_W'(1) : x - POS_W'(1);
    end

endmodule

// File: rtl/car_move_scheduler.sv
// Moves every car through one shared stepper, one car per cycle after each movement tick.
// Tick to o_Frame_Done latency NUM_CARS+1 cycles; ticks arriving mid-scan are dropped and flagged sticky.
module car_move_scheduler
    import car_move_scheduler_pkg::*;
#(
    parameter int                       NUM_CARS     = 4,
    parameter int                       c_MAX_X      = 40,
    parameter int                       c_TICK_COUNT = 2000000,
    parameter logic [NUM_CARS*4-1:0]    c_CAR_PERIOD = {4'd3, 4'd1, 4'd2, 4'd1},
    parameter logic [NUM_CARS-1:0]      c_CAR_DIR    = 4'b1010,
    parameter logic [NUM_CARS*6-1:0]    c_INIT_X     = {6'd30, 6'd20, 6'd10, 6'd0},
    parameter logic [NUM_CARS*6-1:0]    c_INIT_Y     = {6'd8, 6'd7, 6'd6, 6'd5}
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic                      i_Pause,
    input  logic [2:0]                i_Level,
    output logic [NUM_CARS*6-1:0]     o_Car_X,
    output logic [NUM_CARS*6-1:0]     o_Car_Y,
    output logic                      o_Busy,
    output logic                      o_Frame_Done,
    output logic                      o_Overrun
);

    localparam int PS_W  = (c_TICK_COUNT > 1) ? $clog2(c_TICK_COUNT) : 1;
    localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

    logic [PS_W-1:0]   ps_cnt;
    logic              tick;

    scan_state_t       state;
    logic [IDX_W-1:0]  idx;
    logic [POS_W-1:0]  car_x   [NUM_CARS];
    logic [PER_W-1:0]  car_cnt [NUM_CARS];
    logic [NUM_CARS*6-1:0] car_y;

    logic [POS_W-1:0]  cur_x;
    logic [POS_W-1:0]  nxt_x;
    logic              cur_dir;
    logic [PER_W-1:0]  cur_cnt;
    logic [PER_W-1:0]  cur_period;

    assign tick = (ps_cnt == PS_W'(c_TICK_COUNT - 1)) && !i_Pause;

    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            ps_cnt <= '0;
        else if (!i_Pause)
            ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
    end

    assign cur_x      = car_x[idx];
    assign cur_cnt    = car_cnt[idx];
    assign cur_dir    = c_CAR_DIR[idx];
    assign cur_period = c_CAR_PERIOD[int'(idx)*PER_W +: PER_W];

    car_step_unit u_step (
        .x      (cur_x),
        .dir    (cur_dir),
        .max_x  (POS_W'(c_MAX_X)),
        .next_x (nxt_x)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state        <= S_IDLE;
            idx          <= '0;
            o_Busy       <= 1'b0;
            o_Frame_Done <= 1'b0;
            o_Overrun    <= 1'b0;
            car_y        <= c_INIT_Y;
            for (int i = 0; i < NUM_CARS; i++) begin
                car_x[i]   <= c_INIT_X[i*POS_W +: POS_W];
                car_cnt[i] <= '0;
            end
        end else begin
            o_Frame_Done <= 1'b0;
            if (tick && (state != S_IDLE))
                o_Overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        state  <= S_SCAN;
                        idx    <= '0;
                        o_Busy <= 1'b1;
                    end
                end
                S_SCAN: begin
                    // Level is sampled here, so a mid-frame change affects only cars not yet visited.
                    if (cur_cnt == '0) begin
                        car_cnt[idx] <= eff_period(cur_period, i_Level) - PER_W'(1);
                        car_x[idx]   <= nxt_x;
                    end else begin
                        car_cnt[idx] <= cur_cnt - PER_W'(1);
                    end
                    if (idx == IDX_W'(NUM_CARS - 1)) begin
                        state        <= S_DONE;
                        o_Frame_Done <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    o_Busy <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CARS; g++) begin : g_flat
        assign o_Car_X[g*POS_W +: POS_W] = car_x[g];
    end

    assign o_Car_Y = car_y;

endmodule

// File: tb/tb_car_move_scheduler.sv
// Randomized bench: two scheduler instances (fast prescaler with wrap/overrun setup,
// and the reference setup) compared every cycle against a frame-level behavioural model.
module tb_car_move_scheduler;

    localparam int N = 4;

    logic        clk;
    logic        rst;
    logic        pause;
    logic [2:0]  level;

    logic [23:0] xa, ya, xb, yb;
    logic        busy_a, fd_a, ovr_a;
    logic        busy_b, fd_b, ovr_b;

    int n_cmp;
    int n_bad;

    // Model state, index 0 = dut_a, 1 = dut_b
    int mT    [2];
    int mper  [2][N];
    int mdir  [2][N];
    int minit [2][N];
    int mx    [2][N];
    int mcnt  [2][N];
    int mpc   [2];
    int mphase[2];   // -1 idle, 0..N-1 car being visited next edge, N = frame-done cycle
    int movr  [2];

    car_move_scheduler #(.c_TICK_COUNT(8)) dut_a (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_Pause      (pause),
        .i_Level      (level),
        .o_Car_X      (xa),
        .o_Car_Y      (ya),
        .o_Busy       (busy_a),
        .o_Frame_Done (fd_a),
        .o_Overrun    (ovr_a)
    );

    car_move_scheduler #(
        .c_TICK_COUNT (5),
        .c_INIT_X     ({6'd30, 6'd20, 6'd0, 6'd39})
    ) dut_b (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_Pause      (pause),
        .i_Level      (level),
        .o_Car_X      (xb),
        .o_Car_Y      (yb),
        .o_Busy       (busy_b),
        .o_Frame_Done (fd_b),
        .o_Overrun    (ovr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [23:0] model_x(input int m);
        logic [23:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            v[i*6 +: 6] = 6'(mx[m][i]);
        return v;
    endfunction

    task automatic model_reset(input int m);
        mpc[m]    = 0;
        mphase[m] = -1;
        movr[m]   = 0;
        for (int i = 0; i < N; i++) begin
            mx[m][i]   = minit[m][i];
            mcnt[m][i] = 0;
        end
    endtask

    // Applies one clock edge of the rules to model m using the inputs currently driven.
    task automatic model_edge(input int m);
        bit tk;
        int ph, c, p;
        if (rst) begin
            model_reset(m);
            return;
        end
        tk = (mpc[m] == mT[m] - 1) && !pause;
        if (!pause)
            mpc[m] = tk ? 0 : mpc[m] + 1;
        ph = mphase[m];
        if (tk && ph != -1)
            movr[m] = 1;
        if (ph == -1) begin
            if (tk) mphase[m] = 0;
        end else if (ph < N) begin
            c = ph;
            if (mcnt[m][c] == 0) begin
                p = mper[m][c] - int'(level);
                if (p < 1) p = 1;
                mcnt[m][c] = p - 1;
                if (mdir[m][c] == 0)
                    mx[m][c] = (mx[m][c] == 39) ? 0 : mx[m][c] + 1;
                else
                    mx[m][c] = (mx[m][c] == 0) ? 39 : mx[m][c] - 1;
            end else begin
                mcnt[m][c] = mcnt[m][c] - 1;
            end
            mphase[m] = ph + 1;
        end else begin
            mphase[m] = -1;
        end
    endtask

    task automatic compare_all();
        chk("a_x",    32'(xa),     32'(model_x(0)));
        chk("a_busy", 32'(busy_a), 32'(mphase[0] != -1));
        chk("a_done", 32'(fd_a),   32'(mphase[0] == N));
        chk("a_ovr",  32'(ovr_a),  32'(movr[0]));
        chk("b_x",    32'(xb),     32'(model_x(1)));
        chk("b_busy", 32'(busy_b), 32'(mphase[1] != -1));
        chk("b_done", 32'(fd_b),   32'(mphase[1] == N));
        chk("b_ovr",  32'(ovr_b),  32'(movr[1]));
    endtask

    task automatic cycle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge(0);
            model_edge(1);
            @(negedge clk);
            compare_all();
        end
    endtask

    logic [23:0] snap;
    bit          found;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        pause = 1'b0;
        level = 3'd0;
        for (int m = 0; m < 2; m++) begin
            mper[m][0] = 1; mper[m][1] = 2; mper[m][2] = 1; mper[m][3] = 3;
            mdir[m][0] = 0; mdir[m][1] = 1; mdir[m][2] = 0; mdir[m][3] = 1;
        end
        mT[0] = 8;
        mT[1] = 5;
        minit[0][0] = 0;  minit[0][1] = 10; minit[0][2] = 20; minit[0][3] = 30;
        minit[1][0] = 39; minit[1][1] = 0;  minit[1][2] = 20; minit[1][3] = 30;
        model_reset(0);
        model_reset(1);

        @(negedge clk);
        cycle(3);
        chk("rst_x_a",    32'(xa), 32'({6'd30, 6'd20, 6'd10, 6'd0}));
        chk("rst_y_a",    32'(ya), 32'({6'd8, 6'd7, 6'd6, 6'd5}));
        chk("rst_x_b",    32'(xb), 32'({6'd30, 6'd20, 6'd0, 6'd39}));
        chk("rst_flags",  32'({busy_a, fd_a, ovr_a, busy_b, fd_b, ovr_b}), 32'd0);

        rst = 1'b0;
        cycle(7);
        chk("idle7_busy", 32'(busy_a), 32'd0);
        chk("idle7_x",    32'(xa),     32'({6'd30, 6'd20, 6'd10, 6'd0}));
        cycle(1);
        chk("tick_busy",  32'(busy_a), 32'd1);
        cycle(2);
        chk("wrap_right", 32'(xb[5:0]),  32'd0);
        chk("wrap_left",  32'(xb[11:6]), 32'd39);
        chk("ovr_set",    32'(ovr_b),    32'd1);
        cycle(2);
        chk("done_lat",   32'(fd_a),   32'd1);
        chk("done_busy",  32'(busy_a), 32'd1);
        cycle(1);
        chk("done_pulse", 32'(fd_a),   32'd0);
        chk("idle_after", 32'(busy_a), 32'd0);
        chk("frame1_x",   32'(xa),     32'({6'd29, 6'd21, 6'd9, 6'd1}));
        cycle(24);
        chk("frame4_x",   32'(xa),     32'({6'd28, 6'd24, 6'd8, 6'd4}));
        chk("ovr_a_clr",  32'(ovr_a),  32'd0);

        // Random level changes and pause bursts
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 19) == 0) level = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) pause = ~pause;
            cycle(1);
        end
        pause = 1'b0;
        chk("ovr_sticky", 32'(ovr_b), 32'd1);

        level = 3'd7;
        cycle(48);
        chk("lane_y", 32'(ya), 32'({6'd8, 6'd7, 6'd6, 6'd5}));

        pause = 1'b1;
        cycle(8);
        snap = model_x(0);
        cycle(40);
        chk("pause_frozen", 32'(xa), 32'(snap));
        chk("pause_idle",   32'(busy_a), 32'd0);
        pause = 1'b0;
        level = 3'd0;

        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(1);
            if (busy_a && !fd_a) found = 1'b1;
        end
        chk("scan_wait", 32'(found), 32'd1);
        cycle(1);
        rst = 1'b1;
        cycle(1);
        chk("midscan_x_a", 32'(xa), 32'({6'd30, 6'd20, 6'd10, 6'd0}));
        chk("midscan_x_b", 32'(xb), 32'({6'd30, 6'd20, 6'd0, 6'd39}));
        chk("midscan_y",   32'(ya), 32'({6'd8, 6'd7, 6'd6, 6'd5}));
        chk("midscan_flg", 32'({busy_a, fd_a, ovr_a, busy_b, fd_b, ovr_b}), 32'd0);
        rst = 1'b0;
        cycle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
